// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register/data widths, write-back source encoding
// and a register one-hot decode helper.
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int LINK_W     = 26;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_LINK = 2'd2
    } wb_src_t;

    function automatic logic [NUM_REGS-1:0] dest_onehot(input logic [REG_ADDR_W-1:0] d);
        logic [NUM_REGS-1:0] m;
        m    = '0;
        m[d] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/wb_dest_fifo.sv
// Destination-register FIFO for outstanding loads, with occupancy and a
// per-slot valid/dest view used to build the busy scoreboard.
module wb_dest_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_push,
    input  logic [W-1:0]              i_push_dest,
    input  logic                      i_pop,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [$clog2(DEPTH):0]    o_count,
    output logic [W-1:0]              o_head_dest,
    output logic [DEPTH-1:0]          o_ent_vld,
    output logic [DEPTH-1:0][W-1:0]   o_ent_dest
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] r_mem;
    logic [PTR_W-1:0]        r_wptr;
    logic [PTR_W-1:0]        r_rptr;
    logic [PTR_W:0]          r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_push_dest;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (i_pop)
                r_rptr <= r_rptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    assign o_full      = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign o_count     = r_count;
    assign o_head_dest = r_mem[r_rptr];
    assign o_ent_dest  = r_mem;

    // A slot is live when its distance from the read pointer is below occupancy.
    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        logic [PTR_W-1:0] w_off;
        assign w_off        = PTR_W'(g) - r_rptr;
        assign o_ent_vld[g] = ({1'b0, w_off} < r_count);
    end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-back arbiter: load responses > skid entry > new ALU/link
// result. Busy scoreboard is built only when WB_SCOREBOARD_EN is defined.
module regfile_writeback #(
    parameter int LQ_DEPTH = 4,
    parameter int LINK_W   = cpu_pkg::LINK_W
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            alu_valid,
    output logic                            alu_ready,
    input  logic [cpu_pkg::REG_ADDR_W-1:0]  alu_dest,
    input  logic [cpu_pkg::DATA_W-1:0]      alu_data,
    input  logic                            alu_link,
    input  logic [LINK_W-1:0]               alu_link_addr,
    input  logic                            ld_issue_valid,
    output logic                            ld_issue_ready,
    input  logic [cpu_pkg::REG_ADDR_W-1:0]  ld_issue_dest,
    input  logic                            ld_resp_valid,
    input  logic [cpu_pkg::DATA_W-1:0]      ld_resp_data,
    output logic                            wr_en,
    output logic [cpu_pkg::REG_ADDR_W-1:0]  wr_dest,
    output logic                            wr_mem_sel,
    output logic                            wr_link_sel,
    output logic [cpu_pkg::DATA_W-1:0]      wr_alu_data,
    output logic [cpu_pkg::DATA_W-1:0]      wr_mem_data,
    output logic [LINK_W-1:0]               wr_link_addr,
    output logic [cpu_pkg::NUM_REGS-1:0]    busy_mask,
    output logic [$clog2(LQ_DEPTH):0]       ld_pending,
    output logic                            ld_err
);

    import cpu_pkg::*;

    logic                               w_fifo_full;
    logic                               w_fifo_empty;
    logic [REG_ADDR_W-1:0]              w_head_dest;
    logic [LQ_DEPTH-1:0]                w_ent_vld;
    logic [LQ_DEPTH-1:0][REG_ADDR_W-1:0] w_ent_dest;
    logic                               w_push;
    logic                               w_resp;
    logic                               w_alu_acc;

    logic                  r_skid_full;
    logic [REG_ADDR_W-1:0] r_skid_dest;
    logic [DATA_W-1:0]     r_skid_data;
    logic                  r_skid_link;
    logic [LINK_W-1:0]     r_skid_laddr;

    logic                  r_wr_en;
    logic [REG_ADDR_W-1:0] r_wr_dest;
    logic                  r_wr_mem_sel;
    logic                  r_wr_link_sel;
    logic [DATA_W-1:0]     r_wr_alu_data;
    logic [DATA_W-1:0]     r_wr_mem_data;
    logic [LINK_W-1:0]     r_wr_link_addr;
    logic                  r_ld_err;

    logic                  w_wr;
    wb_src_t               w_src;
    logic [REG_ADDR_W-1:0] w_dest;
    logic [DATA_W-1:0]     w_alu_data;
    logic [LINK_W-1:0]     w_laddr;
    logic [NUM_REGS-1:0]   w_busy;

    assign w_push    = ld_issue_valid & ~w_fifo_full;
    assign w_resp    = ld_resp_valid & ~w_fifo_empty;
    assign w_alu_acc = alu_valid & ~r_skid_full;

    wb_dest_fifo #(
        .DEPTH (LQ_DEPTH),
        .W     (REG_ADDR_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_dest (ld_issue_dest),
        .i_pop       (w_resp),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (ld_pending),
        .o_head_dest (w_head_dest),
        .o_ent_vld   (w_ent_vld),
        .o_ent_dest  (w_ent_dest)
    );

    // A non-load write only ever comes from the skid when the skid is occupied.
    assign w_alu_data = r_skid_full ? r_skid_data  : alu_data;
    assign w_laddr    = r_skid_full ? r_skid_laddr : alu_link_addr;

    always_comb begin
        w_wr   = 1'b0;
        w_src  = WB_ALU;
        w_dest = alu_dest;
        if (w_resp) begin
            w_wr   = 1'b1;
            w_src  = WB_MEM;
            w_dest = w_head_dest;
        end else if (r_skid_full) begin
            w_wr   = 1'b1;
            w_src  = r_skid_link ? WB_LINK : WB_ALU;
            w_dest = r_skid_dest;
        end else if (w_alu_acc) begin
            w_wr   = 1'b1;
            w_src  = alu_link ? WB_LINK : WB_ALU;
            w_dest = alu_dest;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_skid_full    <= 1'b0;
            r_wr_en        <= 1'b0;
            r_wr_dest      <= '0;
            r_wr_mem_sel   <= 1'b0;
            r_wr_link_sel  <= 1'b0;
            r_wr_alu_data  <= '0;
            r_wr_mem_data  <= '0;
            r_wr_link_addr <= '0;
            r_ld_err       <= 1'b0;
        end else begin
            if (w_resp && w_alu_acc) begin
                r_skid_full  <= 1'b1;
                r_skid_dest  <= alu_dest;
                r_skid_data  <= alu_data;
                r_skid_link  <= alu_link;
                r_skid_laddr <= alu_link_addr;
            end else if (!w_resp && r_skid_full) begin
                r_skid_full <= 1'b0;
            end

            r_wr_en       <= w_wr;
            r_wr_mem_sel  <= w_wr && (w_src == WB_MEM);
            r_wr_link_sel <= w_wr && (w_src == WB_LINK);
            if (w_wr) begin
                r_wr_dest <= w_dest;
                case (w_src)
                    WB_MEM:  r_wr_mem_data  <= ld_resp_data;
                    WB_LINK: r_wr_link_addr <= w_laddr;
                    default: r_wr_alu_data  <= w_alu_data;
                endcase
            end

            if (ld_resp_valid && w_fifo_empty)
                r_ld_err <= 1'b1;
        end
    end

`ifdef WB_SCOREBOARD_EN
    always_comb begin
        w_busy = '0;
        for (int i = 0; i < LQ_DEPTH; i++)
            if (w_ent_vld[i])
                w_busy = w_busy | dest_onehot(w_ent_dest[i]);
    end
`else
    logic w_unused_view;
    assign w_unused_view = ^{w_ent_vld, w_ent_dest};
    assign w_busy        = '0;
`endif

    assign alu_ready      = ~r_skid_full;
    assign ld_issue_ready = ~w_fifo_full;
    assign busy_mask      = w_busy;
    assign wr_en          = r_wr_en;
    assign wr_dest        = r_wr_dest;
    assign wr_mem_sel     = r_wr_mem_sel;
    assign wr_link_sel    = r_wr_link_sel;
    assign wr_alu_data    = r_wr_alu_data;
    assign wr_mem_data    = r_wr_mem_data;
    assign wr_link_addr   = r_wr_link_addr;
    assign ld_err         = r_ld_err;

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios followed by
// random traffic against a queue-based reference model.
module tb_regfile_writeback;

    localparam int LQ_DEPTH = 4;
    localparam int LINK_W   = 26;
    localparam int PW       = $clog2(LQ_DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              alu_valid, alu_ready, alu_link;
    logic [4:0]        alu_dest;
    logic [31:0]       alu_data;
    logic [LINK_W-1:0] alu_link_addr;
    logic              ld_issue_valid, ld_issue_ready;
    logic [4:0]        ld_issue_dest;
    logic              ld_resp_valid;
    logic [31:0]       ld_resp_data;
    logic              wr_en, wr_mem_sel, wr_link_sel, ld_err;
    logic [4:0]        wr_dest;
    logic [31:0]       wr_alu_data, wr_mem_data, busy_mask;
    logic [LINK_W-1:0] wr_link_addr;
    logic [PW-1:0]     ld_pending;

    regfile_writeback #(.LQ_DEPTH(LQ_DEPTH), .LINK_W(LINK_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest),
        .alu_data(alu_data), .alu_link(alu_link), .alu_link_addr(alu_link_addr),
        .ld_issue_valid(ld_issue_valid), .ld_issue_ready(ld_issue_ready),
        .ld_issue_dest(ld_issue_dest), .ld_resp_valid(ld_resp_valid),
        .ld_resp_data(ld_resp_data), .wr_en(wr_en), .wr_dest(wr_dest),
        .wr_mem_sel(wr_mem_sel), .wr_link_sel(wr_link_sel),
        .wr_alu_data(wr_alu_data), .wr_mem_data(wr_mem_data),
        .wr_link_addr(wr_link_addr), .busy_mask(busy_mask),
        .ld_pending(ld_pending), .ld_err(ld_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]        dest;
        logic [31:0]       data;
        logic              link;
        logic [LINK_W-1:0] laddr;
    } alu_res_t;

    // Reference state: queued load dests, held ALU results, expected write.
    logic [4:0]        ldq[$];
    alu_res_t          skq[$];
    logic              e_wr_en = 1'b0;
    int                e_src   = 0;   // 0 alu, 1 mem, 2 link
    logic [4:0]        e_dest  = '0;
    logic [31:0]       e_data  = '0;
    logic [LINK_W-1:0] e_laddr = '0;
    logic              e_err   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_busy();
        logic [31:0] m = '0;
`ifdef WB_SCOREBOARD_EN
        foreach (ldq[i]) m[ldq[i]] = 1'b1;
`endif
        return m;
    endfunction

    task automatic take(input alu_res_t a);
        e_src   = a.link ? 2 : 0;
        e_dest  = a.dest;
        e_data  = a.data;
        e_laddr = a.laddr;
    endtask

    task automatic model_edge();
        bit       resp_ok, acc, iss;
        alu_res_t a;
        if (!rst_n) begin
            ldq.delete();
            skq.delete();
            e_wr_en = 1'b0;
            e_err   = 1'b0;
            return;
        end
        resp_ok = ld_resp_valid && (ldq.size() > 0);
        acc     = alu_valid && (skq.size() == 0);
        iss     = ld_issue_valid && (ldq.size() < LQ_DEPTH);
        a       = '{alu_dest, alu_data, alu_link, alu_link_addr};
        e_wr_en = 1'b1;
        if (resp_ok) begin
            e_src  = 1;
            e_dest = ldq.pop_front();
            e_data = ld_resp_data;
            if (acc) skq.push_back(a);
        end else if (skq.size() > 0) begin
            take(skq.pop_front());
        end else if (acc) begin
            take(a);
        end else begin
            e_wr_en = 1'b0;
        end
        if (ld_resp_valid && !resp_ok) e_err = 1'b1;
        if (iss) ldq.push_back(ld_issue_dest);
    endtask

    task automatic check_all();
        chk("wr_en", 32'(wr_en), 32'(e_wr_en));
        if (e_wr_en) begin
            chk("wr_dest", 32'(wr_dest), 32'(e_dest));
            chk("mem_sel", 32'(wr_mem_sel), 32'(e_src == 1));
            chk("link_sel", 32'(wr_link_sel), 32'(e_src == 2));
            case (e_src)
                1:       chk("mem_data", wr_mem_data, e_data);
                2:       chk("link_addr", 32'(wr_link_addr), 32'(e_laddr));
                default: chk("alu_data", wr_alu_data, e_data);
            endcase
        end
        chk("alu_ready", 32'(alu_ready), 32'(skq.size() == 0));
        chk("issue_ready", 32'(ld_issue_ready), 32'(ldq.size() < LQ_DEPTH));
        chk("ld_pending", 32'(ld_pending), 32'(ldq.size()));
        chk("busy_mask", busy_mask, exp_busy());
        chk("ld_err", 32'(ld_err), 32'(e_err));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        alu_valid      = 1'b0;
        alu_link       = 1'b0;
        ld_issue_valid = 1'b0;
        ld_resp_valid  = 1'b0;
    endtask

    initial begin
        logic [31:0] bm;
        idle();
        alu_dest = '0; alu_data = '0; alu_link_addr = '0;
        ld_issue_dest = '0; ld_resp_data = '0;

        rst_n = 1'b0;
        step();
        step();
        chk("rst_alu_data", wr_alu_data, 32'h0);
        chk("rst_mem_data", wr_mem_data, 32'h0);
        chk("rst_link_addr", 32'(wr_link_addr), 32'h0);
        chk("rst_dest", 32'(wr_dest), 32'h0);
        chk("rst_sels", 32'({wr_mem_sel, wr_link_sel}), 32'h0);
        rst_n = 1'b1;

        alu_valid = 1'b1; alu_dest = 5'd3; alu_data = 32'hDEADBEEF;
        step(); idle();
        chk("alu_direct_dest", 32'(wr_dest), 32'd3);
        chk("alu_direct_data", wr_alu_data, 32'hDEADBEEF);
        chk("alu_direct_sels", 32'({wr_mem_sel, wr_link_sel}), 32'h0);

        alu_valid = 1'b1; alu_link = 1'b1; alu_dest = 5'd31; alu_link_addr = 26'h40;
        step(); idle();
        chk("link_sel", 32'(wr_link_sel), 32'd1);
        chk("link_dest", 32'(wr_dest), 32'd31);
        chk("link_addr", 32'(wr_link_addr), 32'h40);

        ld_issue_valid = 1'b1; ld_issue_dest = 5'd7; step();
        ld_issue_dest = 5'd20; step(); idle();
        bm = '0;
`ifdef WB_SCOREBOARD_EN
        bm = (32'd1 << 7) | (32'd1 << 20);
`endif
        chk("busy_7_20", busy_mask, bm);
        chk("pending_2", 32'(ld_pending), 32'd2);
        ld_resp_valid = 1'b1; ld_resp_data = 32'h11; step();
        chk("resp1_dest", 32'(wr_dest), 32'd7);
        chk("resp1_data", wr_mem_data, 32'h11);
        chk("pending_1", 32'(ld_pending), 32'd1);
        ld_resp_data = 32'h22; step(); idle();
        chk("resp2_dest", 32'(wr_dest), 32'd20);
        chk("pending_0", 32'(ld_pending), 32'd0);
        step();

        // ALU collides with a load response and must wait one cycle in the skid.
        ld_issue_valid = 1'b1; ld_issue_dest = 5'd7; step(); idle();
        alu_valid = 1'b1; alu_dest = 5'd3; alu_data = 32'd5;
        ld_resp_valid = 1'b1; ld_resp_data = 32'd9;
        step(); idle();
        chk("coll_mem_dest", 32'(wr_dest), 32'd7);
        chk("coll_mem_data", wr_mem_data, 32'd9);
        chk("coll_ready_lo", 32'(alu_ready), 32'd0);
        step();
        chk("coll_skid_dest", 32'(wr_dest), 32'd3);
        chk("coll_skid_data", wr_alu_data, 32'd5);
        chk("coll_ready_hi", 32'(alu_ready), 32'd1);

        ld_issue_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ld_issue_dest = 5'($urandom);
            step();
        end
        chk("full_ready", 32'(ld_issue_ready), 32'd0);
        ld_resp_valid = 1'b1; ld_resp_data = $urandom;
        ld_issue_dest = 5'd9;
        step(); idle();
        chk("full_push_pop", 32'(ld_pending), 32'd3);
        ld_resp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ld_resp_data = $urandom;
            step();
        end
        idle(); step();

        ld_resp_valid = 1'b1; step(); idle();
        chk("empty_resp_wr", 32'(wr_en), 32'd0);
        chk("empty_resp_err", 32'(ld_err), 32'd1);
        step();
        chk("err_sticky", 32'(ld_err), 32'd1);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk("err_cleared", 32'(ld_err), 32'd0);

        // Loads queued before a reset are forgotten.
        ld_issue_valid = 1'b1; ld_issue_dest = 5'd4; step(); step(); idle();
        rst_n = 1'b0; step(); rst_n = 1'b1;
        ld_resp_valid = 1'b1; ld_resp_data = 32'hAA; step(); idle();
        chk("post_rst_wr", 32'(wr_en), 32'd0);
        chk("post_rst_err", 32'(ld_err), 32'd1);
        rst_n = 1'b0; step(); rst_n = 1'b1;

        for (int c = 0; c < 500; c++) begin
            rst_n          = ($urandom_range(0, 149) != 0);
            alu_valid      = 1'($urandom_range(0, 1));
            alu_dest       = 5'($urandom);
            alu_data       = $urandom;
            alu_link       = ($urandom_range(0, 3) == 0);
            alu_link_addr  = LINK_W'($urandom);
            ld_issue_valid = ($urandom_range(0, 2) == 0);
            ld_issue_dest  = 5'($urandom);
            ld_resp_valid  = (ldq.size() > 0) ? ($urandom_range(0, 2) != 0)
                                              : ($urandom_range(0, 60) == 0);
            ld_resp_data   = $urandom;
            step();
        end
        rst_n = 1'b1;
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
